// File: rtl/serial_adder.sv
// Bit-serial adder: feeds one fullAdder cell LSB-first, one bit per clock,
// and registers the WIDTH-bit sum plus final carry on completion.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic [WIDTH-2:0]   r_s_sr;
    logic               r_c;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_co;
    logic               r_busy;
    logic               r_done;
    logic               w_s;
    logic               w_co;
    logic               w_last;
    logic               w_load;
    logic [WIDTH-1:0]   w_sum_next;

    fullAdder u_fa (
        .a  (r_a_sr[0]),
        .b  (r_b_sr[0]),
        .ci (r_c),
        .s  (w_s),
        .co (w_co)
    );

    // Only the upper WIDTH-1 partial-sum bits are ever reused; bit 0 shifts out at completion.
    assign w_sum_next = {w_s, r_s_sr};
    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = SHIFT;
                    w_load       = 1'b1;
                end
            end
            SHIFT: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Operand/carry datapath and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sr <= '0;
            r_b_sr <= '0;
            r_s_sr <= '0;
            r_c    <= 1'b0;
            r_cnt  <= '0;
            r_sum  <= '0;
            r_co   <= 1'b0;
        end else if (w_load) begin
            r_a_sr <= a;
            r_b_sr <= b;
            r_c    <= ci;
            r_cnt  <= '0;
        end else if (r_state == SHIFT) begin
            r_a_sr <= {1'b0, r_a_sr[WIDTH-1:1]};
            r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
            r_s_sr <= w_sum_next[WIDTH-1:1];
            r_c    <= w_co;
            r_cnt  <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_sum <= w_sum_next;
                r_co  <= w_co;
            end
        end
    end

    // Status flags registered from the next state so they line up with r_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_next == SHIFT);
            r_done <= (w_state_next == DONE);
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign co   = r_co;

endmodule

// Single-bit full adder cell.
module fullAdder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: WIDTH=8 directed cases and an exhaustive WIDTH=2 sweep.
module tb_serial_adder;

    logic       clk;
    logic       rst_n;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       ci8;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       co8;

    logic       start2;
    logic [1:0] a2;
    logic [1:0] b2;
    logic       ci2;
    logic       busy2;
    logic       done2;
    logic [1:0] sum2;
    logic       co2;

    int checks;
    int failures;
    int cyc;

    logic [8:0] q8[$];
    logic [2:0] q2[$];
    logic [8:0] last8;
    logic [2:0] last2;
    logic [8:0] e8;
    logic [2:0] e2;
    logic       prev_done8;
    logic       prev_done2;
    int         last_done2_cyc;
    int         n_done2;
    logic       gap_en;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .ci    (ci8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .co    (co8)
    );

    serial_adder #(.WIDTH(2)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start2),
        .a     (a2),
        .b     (b2),
        .ci    (ci2),
        .busy  (busy2),
        .done  (done2),
        .sum   (sum2),
        .co    (co2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // WIDTH=8 monitor: pops the scoreboard on done, otherwise result must hold.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst8_outputs", {22'd0, busy8, done8, co8, sum8}, 32'd0);
            last8 = '0;
        end else if (done8) begin
            if (q8.size() == 0) begin
                flag("done8_unexpected");
            end else begin
                e8 = q8.pop_front();
                chk("result8", {23'd0, co8, sum8}, {23'd0, e8});
                last8 = e8;
            end
            chk("done8_one_cycle", {31'd0, prev_done8}, 32'd0);
        end else begin
            chk("hold8", {23'd0, co8, sum8}, {23'd0, last8});
        end
        prev_done8 = done8;
    end

    // WIDTH=2 monitor: same scoreboard plus done spacing.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst2_outputs", {27'd0, busy2, done2, co2, sum2}, 32'd0);
            last2 = '0;
        end else if (done2) begin
            n_done2++;
            if (q2.size() == 0) begin
                flag("done2_unexpected");
            end else begin
                e2 = q2.pop_front();
                chk("result2", {29'd0, co2, sum2}, {29'd0, e2});
                last2 = e2;
            end
            if (gap_en && last_done2_cyc >= 0)
                chk("done2_spacing", 32'(cyc - last_done2_cyc), 32'd4);
            last_done2_cyc = cyc;
        end else begin
            chk("hold2", {29'd0, co2, sum2}, {29'd0, last2});
        end
        prev_done2 = done2;
    end

    // Present operands and let the next edge accept them; inputs then scrambled.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                          input logic [8:0] exp, input logic push);
        @(posedge clk);
        #1;
        start8 = 1'b1;
        a8 = a;
        b8 = b;
        ci8 = ci;
        if (push) q8.push_back(exp);
        @(posedge clk);
        #1;
        start8 = 1'b0;
        a8 = ~a;
        b8 = ~b;
        ci8 = ~ci;
    endtask

    // Called just after the accepting edge; measures done latency and busy length.
    task automatic wait_done8(input string name);
        int lat;
        int nb;
        lat = 0;
        nb  = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (busy8) nb++;
            if (done8) begin
                lat = k;
                break;
            end
        end
        if (lat == 0) flag({name, "_timeout"});
        else begin
            chk({name, "_latency"}, 32'(lat), 32'd9);
            chk({name, "_busy_cycles"}, 32'(nb), 32'd8);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        failures = 0;
        cyc = 0;
        n_done2 = 0;
        last_done2_cyc = -1;
        gap_en = 1'b0;
        prev_done8 = 1'b0;
        prev_done2 = 1'b0;
        last8 = '0;
        last2 = '0;
        start8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; ci2 = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset: nothing moves without start.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("idle_busy_done", {30'd0, busy8, done8}, 32'd0);
        end

        issue8(8'd100, 8'd27, 1'b0, 9'h07F, 1'b1);
        wait_done8("add_100_27");
        @(negedge clk);
        chk("done_low_after", {31'd0, done8}, 32'd0);

        issue8(8'hFF, 8'h01, 1'b0, 9'h100, 1'b1);
        wait_done8("add_ff_01");
        issue8(8'hA5, 8'h5A, 1'b1, 9'h100, 1'b1);
        wait_done8("add_a5_5a_c");

        // start held high with operands changed mid-operation.
        @(posedge clk);
        #1;
        start8 = 1'b1; a8 = 8'h0F; b8 = 8'h01; ci8 = 1'b0;
        q8.push_back(9'h010);
        @(posedge clk);
        #1;
        a8 = 8'hFF; b8 = 8'hFF;
        wait_done8("held_start_first");
        q8.push_back(9'h1FE);
        @(posedge clk);
        @(posedge clk);
        #1;
        start8 = 1'b0;
        wait_done8("held_start_second");

        // Reset mid-SHIFT discards the operation.
        issue8(8'hF0, 8'h0F, 1'b1, 9'h000, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {22'd0, busy8, done8, co8, sum8}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        issue8(8'h01, 8'h02, 1'b0, 9'h003, 1'b1);
        wait_done8("add_after_reset");

        // WIDTH=2 exhaustive sweep, back-to-back.
        @(posedge clk);
        #1;
        gap_en = 1'b1;
        start2 = 1'b1;
        for (int i = 0; i < 32; i++) begin
            logic [4:0] v;
            v = 5'(i);
            a2  = v[4:3];
            b2  = v[2:1];
            ci2 = v[0];
            q2.push_back(3'({1'b0, v[4:3]}) + 3'({1'b0, v[2:1]}) + 3'({2'b0, v[0]}));
            @(posedge clk);
            #1;
            repeat (3) @(posedge clk);
            #1;
        end
        start2 = 1'b0;
        for (int k = 0; k < 20 && q2.size() != 0; k++) @(negedge clk);
        @(negedge clk);
        chk("w2_done_count", 32'(n_done2), 32'd32);
        chk("q8_drained", 32'(q8.size()), 32'd0);
        chk("q2_drained", 32'(q2.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
